// File: rtl/mm_mxu_skew_feeder_if.sv
// Operand-buffer to MXU edge bundle for the skew feeder.
// The slave modport is the feeder's view; the master modport is the view of
// whatever drives rows in and consumes the skewed lanes (buffer + MXU side).
interface mm_mxu_skew_feeder_if #(
  parameter int LANES = 16,
  parameter int DW    = 8
);
  logic [LANES-1:0]    buff_vld;
  logic [LANES*DW-1:0] buff_data;
  logic                buff_last;
  logic                buff_rdy;
  logic                mxu_rdy;
  logic [LANES-1:0]    mxu_vld;
  logic [LANES*DW-1:0] mxu_data;
  logic                mxu_last;
  logic                busy;

  modport master (
    output buff_vld, buff_data, buff_last, mxu_rdy,
    input  buff_rdy, mxu_vld, mxu_data, mxu_last, busy
  );

  modport slave (
    input  buff_vld, buff_data, buff_last, mxu_rdy,
    output buff_rdy, mxu_vld, mxu_data, mxu_last, busy
  );
endinterface

// File: rtl/mm_mxu_skew_feeder.sv
// Matmul skew feeder: takes one LANES x DW operand row per cycle and presents
// it to the systolic array with lane i delayed by i advancing cycles. Tracks
// tile boundaries, drains the skew after the last row of a tile and flags the
// final diagonal with mxu_last. mxu_rdy=0 freezes every register.
//
// Build option: define MM_SKEW_ZERO_PAD_EN to force mxu_data lanes to zero
// whenever their mxu_vld bit is low; otherwise masked elements pass through.
module mm_mxu_skew_feeder #(
  parameter int LANES = 16,
  parameter int DW    = 8
) (
  input logic                  clk,
  input logic                  rst,
  mm_mxu_skew_feeder_if.slave  bus
);

  localparam int CNT_W = (LANES > 2) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             mxu_last_q, mxu_last_d;

  logic adv;
  logic row_present;
  logic buff_rdy;
  logic accept;

  logic [LANES-1:0]    lane_vld;
  logic [LANES*DW-1:0] lane_data;

  assign adv         = bus.mxu_rdy;
  assign row_present = |bus.buff_vld;
  // Depends only on state and mxu_rdy so the buffer can compute its valid
  // without a combinational loop through this block.
  assign buff_rdy    = bus.mxu_rdy && (state_q != DRAIN);
  assign accept      = row_present && buff_rdy;

  // Per-lane delay lines: lane g holds g+1 stages so its element appears
  // g advancing edges after the row was accepted.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [g:0]         vld_q;
    logic [g:0][DW-1:0] data_q;

    // Shift the lane on each advance; no accept injects a zero bubble.
    always_ff @(posedge clk) begin
      // NOTE: the delay line is reset in full so a reset mid-tile can never
      // let stale elements reach the MXU afterwards.
      if (rst) begin
        vld_q  <= '0;
        data_q <= '0;
      end else if (adv) begin
        // Data is captured even for a masked lane; only the vld bit is gated.
        vld_q[0]  <= accept & bus.buff_vld[g];
        data_q[0] <= accept ? bus.buff_data[g*DW +: DW] : '0;
        for (int k = 1; k <= g; k++) begin
          vld_q[k]  <= vld_q[k-1];
          data_q[k] <= data_q[k-1];
        end
      end
    end

    assign lane_vld[g]             = vld_q[g];
    assign lane_data[g*DW +: DW]   = data_q[g];
  end

  // Tile tracking state; all advance gating lives in the next-state logic.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      mxu_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      mxu_last_q  <= mxu_last_d;
    end
  end

  // Next state: tile boundary detection and drain countdown, frozen on stall.
  always_comb begin
    // NOTE: every output of this block gets a default first, otherwise paths
    // that skip an assignment would infer latches.
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    mxu_last_d  = mxu_last_q;

    if (adv) begin
      mxu_last_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d     = bus.buff_last ? DRAIN : FILL;
            drain_cnt_d = '0;
          end
        end
        FILL: begin
          if (accept && bus.buff_last) begin
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end
        end
        DRAIN: begin
          // The edge that moves the last row into lane LANES-1 also raises
          // mxu_last, so the flag lines up with the final diagonal.
          if (drain_cnt_q == CNT_W'(LANES - 2)) begin
            mxu_last_d  = 1'b1;
            state_d     = IDLE;
            drain_cnt_d = '0;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d     = IDLE;
          drain_cnt_d = '0;
        end
      endcase
    end
  end

`ifdef MM_SKEW_ZERO_PAD_EN
  logic [LANES*DW-1:0] data_pad;

  // Zero every lane whose valid is low so the MXU sees clean padding.
  always_comb begin
    data_pad = '0;
    for (int l = 0; l < LANES; l++) begin
      if (lane_vld[l]) data_pad[l*DW +: DW] = lane_data[l*DW +: DW];
    end
  end

  assign bus.mxu_data = data_pad;
`else
  assign bus.mxu_data = lane_data;
`endif

  assign bus.buff_rdy = buff_rdy;
  assign bus.mxu_vld  = lane_vld;
  assign bus.mxu_last = mxu_last_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mm_mxu_skew_feeder.sv
// Scoreboard bench for mm_mxu_skew_feeder. Stimulus pushes the hand-derived
// output beats of each tile (absolute cycle, lane valids, data, last) into a
// queue; a negedge monitor pops one beat whenever the MXU side consumes an
// output. Honours MM_SKEW_ZERO_PAD_EN for the expected data of masked lanes.
module tb_mm_mxu_skew_feeder;
  localparam int LANES = 16;
  localparam int DW    = 8;
  localparam int W     = LANES * DW;

  typedef struct {
    int             cyc;
    logic [LANES-1:0] vld;
    logic [W-1:0]   data;
    logic           last;
  } beat_t;

  logic  clk;
  logic  rst;
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  int    n_last = 0;
  bit    mon_en = 0;
  beat_t sb[$];
  beat_t mon_b;

  mm_mxu_skew_feeder_if #(.LANES(LANES), .DW(DW)) bus ();

  mm_mxu_skew_feeder #(.LANES(LANES), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected output at cycle c of a tile (cycle 1 = first cycle after the
  // accept edge of row 0), rows accepted on consecutive edges, full-row
  // element value 16*r + lane + off.
  function automatic beat_t calc_beat(int nrows, logic [LANES-1:0] mask, int off, int c, int last_c);
    beat_t b;
    int    r;
    b.cyc  = 0;
    b.vld  = '0;
    b.data = '0;
    b.last = (c == last_c);
    for (int i = 0; i < LANES; i++) begin
      r = c - 1 - i;
      if (r >= 0 && r < nrows) begin
        b.vld[i] = mask[i];
`ifdef MM_SKEW_ZERO_PAD_EN
        if (mask[i]) b.data[i*DW +: DW] = DW'(16 * r + i + off);
`else
        b.data[i*DW +: DW] = DW'(16 * r + i + off);
`endif
      end
    end
    return b;
  endfunction

  function automatic logic [W-1:0] make_row(int r, int off);
    logic [W-1:0] row;
    row = '0;
    for (int i = 0; i < LANES; i++) row[i*DW +: DW] = DW'(16 * r + i + off);
    return row;
  endfunction

  task automatic push_tile(int nrows, logic [LANES-1:0] mask, int off, int t0,
                           int last_c, int max_c, int stall_at, int stall_len);
    beat_t b;
    for (int c = 1; c <= max_c; c++) begin
      b = calc_beat(nrows, mask, off, c, last_c);
      if ((|b.vld) || b.last) begin
        b.cyc = t0 + c + ((stall_len > 0 && c >= stall_at) ? stall_len : 0);
        sb.push_back(b);
      end
    end
  endtask

  task automatic idle_inputs();
    bus.buff_vld  = '0;
    bus.buff_data = '0;
    bus.buff_last = 1'b0;
  endtask

  task automatic send_row(logic [LANES-1:0] mask, logic [W-1:0] data, logic last);
    check("buff_rdy before row", W'(bus.buff_rdy), W'(1));
    bus.buff_vld  = mask;
    bus.buff_data = data;
    bus.buff_last = last;
    step();
  endtask

  // Monitor: a beat is consumed when the MXU advances while output is shown.
  always @(negedge clk) begin
    if (mon_en && !rst && bus.mxu_rdy && ((|bus.mxu_vld) || bus.mxu_last)) begin
      if (bus.mxu_last) n_last++;
      if (sb.size() == 0) begin
        check("unexpected beat {last,vld}", W'({bus.mxu_last, bus.mxu_vld}), W'(0));
      end else begin
        mon_b = sb.pop_front();
        check("beat cycle", W'(cyc), W'(mon_b.cyc));
        check("beat mxu_vld", W'(bus.mxu_vld), W'(mon_b.vld));
        check("beat mxu_data", bus.mxu_data, mon_b.data);
        check("beat mxu_last", W'(bus.mxu_last), W'(mon_b.last));
      end
    end
  end

  initial begin
    int    t0;
    int    tb_b;
    int    lasts0;
    beat_t eb;

    rst         = 1'b1;
    bus.mxu_rdy = 1'b1;
    idle_inputs();
    repeat (3) step();
    rst = 1'b0;

    check("reset mxu_vld", W'(bus.mxu_vld), W'(0));
    check("reset mxu_data", bus.mxu_data, W'(0));
    check("reset mxu_last", W'(bus.mxu_last), W'(0));
    check("reset busy", W'(bus.busy), W'(0));
    check("reset buff_rdy", W'(bus.buff_rdy), W'(1));
    mon_en = 1'b1;

    // Single-row tile: lane i = i+1, last on the only row.
    t0 = cyc;
    push_tile(1, '1, 1, t0, 16, 16, 0, 0);
    send_row('1, make_row(0, 1), 1'b1);
    idle_inputs();
    for (int k = 1; k <= 16; k++) begin
      check($sformatf("t1 buff_rdy c%0d", k), W'(bus.buff_rdy), W'(k == 16));
      check($sformatf("t1 busy c%0d", k), W'(bus.busy), W'(k != 16));
      step();
    end
    repeat (2) step();

    // Four-row tile, lane data 16*r + i.
    t0 = cyc;
    push_tile(4, '1, 0, t0, 19, 19, 0, 0);
    for (int r = 0; r < 4; r++) send_row('1, make_row(r, 0), 1'(r == 3));
    idle_inputs();
    repeat (18) step();
    check("t2 busy after tile", W'(bus.busy), W'(0));

    // Column mask 00FF, two rows.
    t0 = cyc;
    push_tile(2, 16'h00FF, 'h80, t0, 17, 17, 0, 0);
    for (int r = 0; r < 2; r++) send_row(16'h00FF, make_row(r, 'h80), 1'(r == 1));
    idle_inputs();
    repeat (18) step();
    check("t3 busy after tile", W'(bus.busy), W'(0));

    // Four-row tile with a 3-cycle stall mid-drain (cycles 8..10).
    t0 = cyc;
    push_tile(4, '1, 0, t0, 19, 19, 8, 3);
    for (int r = 0; r < 4; r++) send_row('1, make_row(r, 0), 1'(r == 3));
    idle_inputs();
    while (cyc < t0 + 8) step();
    bus.mxu_rdy = 1'b0;
    eb = calc_beat(4, '1, 0, 8, 19);
    for (int k = 0; k < 3; k++) begin
      check("t4 frozen mxu_vld", W'(bus.mxu_vld), W'(eb.vld));
      check("t4 frozen mxu_data", bus.mxu_data, eb.data);
      check("t4 frozen mxu_last", W'(bus.mxu_last), W'(eb.last));
      check("t4 stall buff_rdy", W'(bus.buff_rdy), W'(0));
      step();
    end
    bus.mxu_rdy = 1'b1;
    while (cyc < t0 + 23) step();
    check("t4 busy after tile", W'(bus.busy), W'(0));

    // Back-to-back single-row tiles A then B.
    lasts0 = n_last;
    t0 = cyc;
    push_tile(1, '1, 'h20, t0, 16, 16, 0, 0);
    send_row('1, make_row(0, 'h20), 1'b1);
    idle_inputs();
    for (int k = 0; k < 40 && !bus.buff_rdy; k++) step();
    check("t5 B accept cycle", W'(cyc - t0), W'(16));
    tb_b = cyc;
    push_tile(1, '1, 'h40, tb_b, 16, 16, 0, 0);
    send_row('1, make_row(0, 'h40), 1'b1);
    idle_inputs();
    repeat (18) step();
    check("t5 mxu_last count", W'(n_last - lasts0), W'(2));

    // Reset in the middle of a filling tile.
    t0 = cyc;
    push_tile(3, '1, 'h60, t0, -1, 4, 0, 0);
    for (int r = 0; r < 3; r++) send_row('1, make_row(r, 'h60), 1'b0);
    idle_inputs();
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6 post-reset mxu_vld", W'(bus.mxu_vld), W'(0));
    check("t6 post-reset mxu_data", bus.mxu_data, W'(0));
    check("t6 post-reset mxu_last", W'(bus.mxu_last), W'(0));
    check("t6 post-reset busy", W'(bus.busy), W'(0));
    check("t6 post-reset buff_rdy", W'(bus.buff_rdy), W'(bus.mxu_rdy));
    repeat (25) step();

    check("scoreboard drained", W'(sb.size()), W'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
